// File: rtl/exec_wb_stage.sv
// exec_wb_stage: execute/writeback stage sitting directly after the 8-bit register file.
// Resolves operands (with forwarding of the pending writeback), runs single-cycle ALU ops
// and drives the register file write port. Define EXEC_MUL_EN to build the iterative
// shift-add multiplier (op 8); without it op 8 behaves as a NOP and issue_ready stays high.
module exec_wb_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_d_address,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              flag_z,
  output logic              flag_c
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd9;

  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              alu_c;
  logic              alu_wr;
  logic              alu_flags;
  logic              accept;

`ifdef EXEC_MUL_EN
  localparam logic [3:0]  OP_MUL = 4'd8;
  localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [ADDR_W-1:0] mul_d_addr;
  logic [CNT_W-1:0]  cnt;

  // Partial product for the current multiplier bit; only the low DATA_W bits are kept
  assign acc_next    = mplier[0] ? (acc + mcand) : acc;
  assign issue_ready = (state == S_IDLE);
`else
  assign issue_ready = 1'b1;
`endif

  assign accept = issue_valid && issue_ready;

  // Operand forwarding from the write still waiting to land in the register file
  always_comb begin
    opnd_a = (rf_write && (rf_d_address == a_addr)) ? rf_data_in : a_data;
    opnd_b = (rf_write && (rf_d_address == b_addr)) ? rf_data_in : b_data;
  end

  // Single-cycle ALU: result, carry/borrow, whether it writes and whether it touches flags
  always_comb begin
    sum       = {1'b0, opnd_a} + {1'b0, opnd_b};
    diff      = {1'b0, opnd_a} - {1'b0, opnd_b};
    alu_res   = '0;
    alu_c     = flag_c;
    alu_wr    = 1'b0;
    alu_flags = 1'b0;
    case (op)
      OP_ADD: begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  alu_wr = 1'b1; alu_flags = 1'b1; end
      OP_SUB: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; alu_wr = 1'b1; alu_flags = 1'b1; end
      OP_AND: begin alu_res = opnd_a & opnd_b; alu_wr = 1'b1; alu_flags = 1'b1; end
      OP_OR:  begin alu_res = opnd_a | opnd_b; alu_wr = 1'b1; alu_flags = 1'b1; end
      OP_XOR: begin alu_res = opnd_a ^ opnd_b; alu_wr = 1'b1; alu_flags = 1'b1; end
      OP_SHL: begin
        alu_res = {opnd_a[DATA_W-2:0], 1'b0};
        alu_c   = opnd_a[DATA_W-1];
        alu_wr  = 1'b1; alu_flags = 1'b1;
      end
      OP_SHR: begin
        alu_res = {1'b0, opnd_a[DATA_W-1:1]};
        alu_c   = opnd_a[0];
        alu_wr  = 1'b1; alu_flags = 1'b1;
      end
      OP_MOV: begin alu_res = opnd_b; alu_wr = 1'b1; alu_flags = 1'b1; end
      OP_CMP: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; alu_flags = 1'b1; end
      default: ;
    endcase
  end

  // Stage state: writeback port, flags and (optionally) the multiplier sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write     <= 1'b0;
      rf_d_address <= '0;
      rf_data_in   <= '0;
      flag_z       <= 1'b0;
      flag_c       <= 1'b0;
`ifdef EXEC_MUL_EN
      state        <= S_IDLE;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      cnt          <= '0;
      mul_d_addr   <= '0;
`endif
    end else begin
      rf_write <= 1'b0;
`ifdef EXEC_MUL_EN
      if (state == S_MUL) begin
        acc    <= acc_next;
        mcand  <= {mcand[DATA_W-2:0], 1'b0};
        mplier <= {1'b0, mplier[DATA_W-1:1]};
        cnt    <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(DATA_W - 1)) begin
          rf_write     <= 1'b1;
          rf_d_address <= mul_d_addr;
          rf_data_in   <= acc_next;
          flag_z       <= (acc_next == '0);
          state        <= S_IDLE;
        end
      end else if (accept && (op == OP_MUL)) begin
        mcand      <= opnd_a;
        mplier     <= opnd_b;
        acc        <= '0;
        cnt        <= '0;
        mul_d_addr <= d_addr;
        state      <= S_MUL;
      end else
`endif
      if (accept) begin
        if (alu_wr) begin
          rf_write     <= 1'b1;
          rf_d_address <= d_addr;
          rf_data_in   <= alu_res;
        end
        if (alu_flags) begin
          flag_z <= (alu_res == '0);
          flag_c <= alu_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_wb_stage.sv
// tb_exec_wb_stage: scoreboard bench for exec_wb_stage with a behavioural register-file model.
// The MUL scenarios are built only when EXEC_MUL_EN is defined.
module tb_exec_wb_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 1'b0;
  logic       issue_ready;
  logic [3:0] op = 4'd0;
  logic [7:0] a_addr = 8'd0, b_addr = 8'd0, d_addr = 8'd0;
  logic [7:0] a_data = 8'd0, b_data = 8'd0;
  logic       rf_write;
  logic [7:0] rf_d_address;
  logic [7:0] rf_data_in;
  logic       flag_z, flag_c;

  exec_wb_stage #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op(op), .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
    .d_addr(d_addr), .rf_write(rf_write), .rf_d_address(rf_d_address),
    .rf_data_in(rf_data_in), .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  typedef struct { int due; bit wr; int addr; int data; bit z; bit c; } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   busy_until = 0;
  int   committed[256];
  int   arch[256];
  bit   pend_v = 0;
  int   pend_a = 0, pend_d = 0;
  int   m_addr = 0, m_data = 0;
  bit   m_z = 0, m_c = 0;

  // Reference model: architectural effect of one accepted instruction, expectation queued
  task automatic accept_model(input int opc, input int a, input int b, input int d);
    exp_t e;
    int   r;
    bit   wr;
    e.due = cyc + 1;
    wr = 1'b1;
    r = 0;
    case (opc)
      0: begin r = a + b; m_c = (r > 255); r = r % 256; end
      1: begin m_c = (a < b); r = (a - b + 256) % 256; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin m_c = (a >= 128); r = (a * 2) % 256; end
      6: begin m_c = (a % 2 == 1); r = a / 2; end
      7: r = b;
`ifdef EXEC_MUL_EN
      8: begin r = (a * b) % 256; e.due = cyc + 9; busy_until = cyc + 9; end
`endif
      9: begin m_c = (a < b); m_z = (a == b); wr = 1'b0; end
      default: wr = 1'b0;
    endcase
    if (wr) begin
      m_z = (r == 0);
      m_addr = d;
      m_data = r;
      arch[d] = r;
    end
    e.wr = wr; e.addr = m_addr; e.data = m_data; e.z = m_z; e.c = m_c;
    sb_q.push_back(e);
  endtask

  // One cycle of stimulus; the register file commits a write one edge after rf_write
  task automatic drive(input bit v, input int opc, input int aa, input int ba, input int da,
                       output bit accepted);
    @(negedge clk);
    if (pend_v) committed[pend_a] = pend_d;
    pend_v = rf_write; pend_a = int'(rf_d_address); pend_d = int'(rf_data_in);
    issue_valid = v;
    op = 4'(opc);
    a_addr = 8'(aa); b_addr = 8'(ba); d_addr = 8'(da);
    a_data = 8'(committed[aa]); b_data = 8'(committed[ba]);
    accepted = v && (issue_ready === 1'b1);
    if (accepted) accept_model(opc, arch[aa], arch[ba], da);
  endtask

  task automatic issue(input int opc, input int aa, input int ba, input int da);
    bit acc_f = 1'b0;
    for (int i = 0; i < 20 && !acc_f; i++) drive(1'b1, opc, aa, ba, da, acc_f);
    if (!acc_f) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout op=%0d got ready=%0b want accept within 20 cycles", opc, issue_ready);
    end
  endtask

  task automatic idle(input int n);
    bit dummy;
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0, dummy);
  endtask

  task automatic set_reg(input int r, input int v);
    committed[r] = v; arch[r] = v;
  endtask

  // Asynchronous reset between clock edges; outputs must clear without a clock
  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1; issue_valid = 1'b0;
    #1;
    vectors++;
    if (rf_write !== 1'b0 || rf_d_address !== 8'd0 || rf_data_in !== 8'd0 ||
        flag_z !== 1'b0 || flag_c !== 1'b0 || issue_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_outputs got wr=%0b addr=%0h data=%0h z=%0b c=%0b rdy=%0b want 0 0 0 0 0 1",
               rf_write, rf_d_address, rf_data_in, flag_z, flag_c, issue_ready);
    end
    sb_q.delete();
    pend_v = 0; busy_until = 0;
    m_addr = 0; m_data = 0; m_z = 0; m_c = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) arch[i] = committed[i];
  endtask

  // Monitor: compare DUT outputs against queued expectations after every edge
  task automatic check_cycle();
    exp_t e;
    bit   exp_rdy;
    exp_rdy = (cyc >= busy_until);
    vectors++;
    if (issue_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL issue_ready cyc=%0d got %0b want %0b", cyc, issue_ready, exp_rdy);
    end
    if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      vectors++;
      if (e.due != cyc || rf_write !== e.wr || rf_d_address !== 8'(e.addr) ||
          rf_data_in !== 8'(e.data) || flag_z !== e.z || flag_c !== e.c) begin
        miscompares++;
        $display("FAIL wb_result cyc=%0d due=%0d got wr=%0b addr=%0h data=%0h z=%0b c=%0b want wr=%0b addr=%0h data=%0h z=%0b c=%0b",
                 cyc, e.due, rf_write, rf_d_address, rf_data_in, flag_z, flag_c,
                 e.wr, e.addr, e.data, e.z, e.c);
      end
    end else if (rf_write !== 1'b0) begin
      vectors++; miscompares++;
      $display("FAIL spurious_write cyc=%0d got wr=%0b addr=%0h data=%0h want wr=0",
               cyc, rf_write, rf_d_address, rf_data_in);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (!rst) check_cycle();
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dummy;
    for (int i = 0; i < 256; i++) begin committed[i] = int'($urandom_range(0, 255)); arch[i] = committed[i]; end
    do_reset();

    // ADD with carry out, then SUB to zero
    set_reg(2, 8'hF0); set_reg(3, 8'h20); set_reg(6, 8'h03); set_reg(7, 8'h03);
    issue(0, 2, 3, 5);
    issue(1, 6, 7, 8);
    idle(2);

    // Dependent MOV right behind ADD: r1 is still stale in the register file
    set_reg(2, 8'h03); set_reg(3, 8'h04); set_reg(1, 8'h00);
    issue(0, 2, 3, 1);
    issue(7, 0, 1, 4);
    issue(0, 4, 1, 4);          // both operands forwarded/committed, d == a
    idle(2);

    // CMP sets borrow without writing; NOP and op 8 leave things alone when no multiplier
    set_reg(30, 8'h02); set_reg(31, 8'h05);
    issue(9, 30, 31, 33);
    issue(12, 30, 31, 34);
`ifndef EXEC_MUL_EN
    issue(8, 30, 31, 35);
    issue(8, 31, 31, 36);
`endif
    idle(2);

`ifdef EXEC_MUL_EN
    // Multiply, then multiply to zero, then a dependent add straight after the write
    set_reg(20, 8'h0D); set_reg(21, 8'h0B); set_reg(22, 8'h10); set_reg(23, 8'h10);
    issue(8, 20, 21, 9);
    issue(8, 22, 23, 24);
    issue(0, 24, 9, 25);
    idle(3);

    // Reset part-way through a multiply: nothing may be written
    set_reg(40, 8'h03); set_reg(41, 8'h05); set_reg(42, 8'h55);
    issue(8, 40, 41, 42);
    idle(3);
    do_reset();
    idle(12);
    vectors++;
    if (committed[42] != 8'h55) begin
      miscompares++;
      $display("FAIL mul_abort got r42=%0h want 55", committed[42]);
    end
`endif

    // Randomised traffic on a small register window to force many dependencies
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), dummy);
    end
    idle(12);

    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
